// File: rtl/rpn_pkg.sv
// Shared opcode values and FSM state encoding for the RPN sequencer slice.
package rpn_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DUP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP_B = 3'd1,
        ST_POP_A = 3'd2,
        ST_EXEC  = 3'd3,
        ST_PUSH  = 3'd4
    } state_t;

endpackage

// File: rtl/rpn_lifo.sv
// Private LIFO for the RPN sequencer: synchronous write, combinational top read.
module rpn_lifo #(
    parameter int W = 4,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [B-1:0] wr_data,
    output logic [B-1:0] top,
    output logic [W:0]   depth,
    output logic         full,
    output logic         empty
);

    logic [B-1:0] mem_q [2**W];
    logic [W:0]   depth_q;
    logic [W:0]   depth_d;
    logic [W-1:0] rd_idx_s;

    assign full     = depth_q[W];
    assign empty    = (depth_q == {(W+1){1'b0}});
    assign depth    = depth_q;
    // Wraps to the last slot when full, which is exactly the top entry then.
    assign rd_idx_s = depth_q[W-1:0] - W'(1);
    assign top      = empty ? {B{1'b0}} : mem_q[rd_idx_s];

    // Next occupancy; push and pop are never requested together.
    always_comb begin
        depth_d = depth_q;
        if (push && !full) begin
            depth_d = depth_q + (W+1)'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - (W+1)'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= {(W+1){1'b0}};
        end else begin
            depth_q <= depth_d;
        end
    end

    // Storage array; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[depth_q[W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/rpn_sequencer.sv
// Reverse-Polish sequencer: drives a private LIFO from a token stream.
// Define RPN_MUL_EN to enable opcode 10 (MUL); otherwise it raises ill_err.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int W = 4,
    parameter int B = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic         tok_is_op,
    input  logic [B-1:0] tok_data,
    output logic [B-1:0] result,
    output logic         result_valid,
    output logic [B-1:0] top,
    output logic [W:0]   depth,
    output logic         ovf_err,
    output logic         unf_err,
    output logic         ill_err,
    input  logic         err_clr
);

    state_t       state_q, state_d;
    logic [B-1:0] a_q, a_d, b_q, b_d, r_q, r_d, result_q, result_d;
    logic [1:0]   op_q, op_d;
    logic         tok_ready_q, tok_ready_d, rv_q, rv_d;
    logic         ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;
    logic         ovf_set_s, unf_set_s, ill_set_s;
    logic         push_s, pop_s, full_s, empty_s, tok_acc_s;
    logic [B-1:0] wr_data_s;

    function automatic logic [B-1:0] alu(input logic [1:0] op,
                                         input logic [B-1:0] a,
                                         input logic [B-1:0] b);
        case (op)
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
`ifdef RPN_MUL_EN
            OP_MUL:  alu = a * b;
`endif
            default: alu = {B{1'b0}};
        endcase
    endfunction

    rpn_lifo #(.W(W), .B(B)) u_lifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (wr_data_s),
        .top     (top),
        .depth   (depth),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign tok_acc_s    = tok_valid && tok_ready_q;
    assign tok_ready    = tok_ready_q;
    assign result       = result_q;
    assign result_valid = rv_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;
    assign ill_err      = ill_q;

    // Next-state, datapath and stack-control decode.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        op_d      = op_q;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        wr_data_s = r_q;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        ill_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!tok_acc_s) begin
                    state_d = ST_IDLE;
                end else if (!tok_is_op) begin
                    if (!full_s) begin
                        push_s    = 1'b1;
                        wr_data_s = tok_data;
                    end else begin
                        ovf_set_s = 1'b1;
                    end
                end else begin
                    case (tok_data[1:0])
                        OP_DUP: begin
                            if (empty_s) begin
                                unf_set_s = 1'b1;
                            end else if (full_s) begin
                                ovf_set_s = 1'b1;
                            end else begin
                                r_d     = top;
                                state_d = ST_PUSH;
                            end
                        end
`ifndef RPN_MUL_EN
                        // Illegal opcode is reported ahead of any underflow.
                        OP_MUL: ill_set_s = 1'b1;
`endif
                        default: begin
                            if (depth >= (W+1)'(2)) begin
                                op_d    = tok_data[1:0];
                                state_d = ST_POP_B;
                            end else begin
                                unf_set_s = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_POP_B: begin
                b_d     = top;
                pop_s   = 1'b1;
                state_d = ST_POP_A;
            end
            ST_POP_A: begin
                a_d     = top;
                pop_s   = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                r_d     = alu(op_q, a_q, b_q);
                state_d = ST_PUSH;
            end
            ST_PUSH: begin
                push_s  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        if (state_d == ST_PUSH) begin
            rv_d     = 1'b1;
            result_d = r_d;
        end else begin
            rv_d     = 1'b0;
            result_d = result_q;
        end
        tok_ready_d = (state_d == ST_IDLE);
        ovf_d = ovf_set_s | (ovf_q & ~err_clr);
        unf_d = unf_set_s | (unf_q & ~err_clr);
        ill_d = ill_set_s | (ill_q & ~err_clr);
    end

    // FSM, operand/result registers and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= {B{1'b0}};
            b_q         <= {B{1'b0}};
            r_q         <= {B{1'b0}};
            op_q        <= 2'b00;
            result_q    <= {B{1'b0}};
            rv_q        <= 1'b0;
            tok_ready_q <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            op_q        <= op_d;
            result_q    <= result_d;
            rv_q        <= rv_d;
            tok_ready_q <= tok_ready_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            ill_q       <= ill_d;
        end
    end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: vector table plus scoreboard of results.
module tb_rpn_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_is_op = 1'b0;
    logic [7:0] tok_data = 8'h00;
    logic [7:0] result;
    logic       result_valid;
    logic [7:0] top;
    logic [4:0] depth;
    logic       ovf_err, unf_err, ill_err;
    logic       err_clr = 1'b0;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [7:0] val;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       clr;
        logic       op;
        logic [7:0] d;
        logic       rv;
        logic [7:0] res;
        int         lat;
        logic [4:0] dep;
        logic [7:0] tp;
        logic       ovf;
        logic       unf;
        logic       ill;
    } vec_t;
    vec_t tbl[14];

    rpn_sequencer #(.W(4), .B(8)) dut (
        .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_is_op(tok_is_op), .tok_data(tok_data), .result(result),
        .result_valid(result_valid), .top(top), .depth(depth),
        .ovf_err(ovf_err), .unf_err(unf_err), .ill_err(ill_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tok_valid && tok_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest expected result and latency.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_result: got %0h expected no pulse", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", {24'h0, result}, {24'h0, e.val});
                chk("result_latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        tok_valid = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic op, input logic [7:0] d, input logic clr,
                        input logic rv, input logic [7:0] res, input int lat);
        int n = 0;
        while (!tok_ready && n < 50) begin @(negedge clk); n++; end
        if (!tok_ready) begin
            nchk++; nerr++;
            $display("FAIL send_timeout: tok_ready got 0 expected 1");
        end
        tok_valid = 1'b1; tok_is_op = op; tok_data = d; err_clr = clr;
        @(posedge clk); #1;
        tok_valid = 1'b0; err_clr = 1'b0;
        if (rv) sb.push_back('{res, lat, cyc});
    endtask

    task automatic clr_pulse();
        @(negedge clk); err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
    endtask

    task automatic settle_chk(input string tag, input logic [4:0] dep, input logic [7:0] tp,
                              input logic ovf, input logic unf, input logic ill);
        int n = 0;
        @(negedge clk);
        while (!tok_ready && n < 50) begin @(negedge clk); n++; end
        if (!tok_ready) begin
            nchk++; nerr++;
            $display("FAIL %s_idle_timeout: tok_ready got 0 expected 1", tag);
        end
        chk({tag, "_depth"}, {27'h0, depth}, {27'h0, dep});
        chk({tag, "_top"}, {24'h0, top}, {24'h0, tp});
        chk({tag, "_ovf"}, {31'h0, ovf_err}, {31'h0, ovf});
        chk({tag, "_unf"}, {31'h0, unf_err}, {31'h0, unf});
        chk({tag, "_ill"}, {31'h0, ill_err}, {31'h0, ill});
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, a1, acc0;
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'd3,  1'b0, 8'h00, 0, 5'd1, 8'd3,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'd5,  1'b0, 8'h00, 0, 5'd2, 8'd5,  1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 8'd8,  4, 5'd1, 8'd8,  1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 8'd2,  1'b0, 8'h00, 0, 5'd2, 8'd2,  1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'd7,  1'b0, 8'h00, 0, 5'd3, 8'd7,  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h01, 1'b1, 8'hFB, 4, 5'd2, 8'hFB, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'd200,1'b0, 8'h00, 0, 5'd3, 8'hC8, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'd100,1'b0, 8'h00, 0, 5'd4, 8'h64, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h2C, 4, 5'd3, 8'h2C, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h2C, 1, 5'd4, 8'h2C, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, 4, 5'd3, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h03, 1'b1, 8'h00, 1, 5'd4, 8'h00, 1'b0, 1'b0, 1'b0};

        reset_dut();
        chk("reset_depth", {27'h0, depth}, 32'd0);
        chk("reset_top", {24'h0, top}, 32'd0);
        chk("reset_ready", {31'h0, tok_ready}, 32'd1);
        chk("reset_result", {24'h0, result}, 32'd0);
        chk("reset_rv", {31'h0, result_valid}, 32'd0);
        chk("reset_flags", {29'h0, ovf_err, unf_err, ill_err}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].clr) clr_pulse();
            else send(tbl[i].op, tbl[i].d, 1'b0, tbl[i].rv, tbl[i].res, tbl[i].lat);
            settle_chk($sformatf("vec%0d", i), tbl[i].dep, tbl[i].tp,
                       tbl[i].ovf, tbl[i].unf, tbl[i].ill);
        end

        // Overflow on full stack, clear, then DUP on full.
        reset_dut();
        for (int i = 0; i < 16; i++) send(1'b0, 8'(10 + i), 1'b0, 1'b0, 8'h00, 0);
        settle_chk("fill16", 5'd16, 8'd25, 1'b0, 1'b0, 1'b0);
        send(1'b0, 8'd99, 1'b0, 1'b0, 8'h00, 0);
        settle_chk("push17", 5'd16, 8'd25, 1'b1, 1'b0, 1'b0);
        clr_pulse();
        settle_chk("ovf_clr", 5'd16, 8'd25, 1'b0, 1'b0, 1'b0);
        send(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 0);
        settle_chk("dup_full", 5'd16, 8'd25, 1'b1, 1'b0, 1'b0);

        // Underflow, set-wins-over-clear, then DUP of a single entry.
        reset_dut();
        send(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        settle_chk("add_empty", 5'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 0);
        settle_chk("set_wins", 5'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        clr_pulse();
        send(1'b0, 8'd9, 1'b0, 1'b0, 8'h00, 0);
        send(1'b1, 8'h03, 1'b0, 1'b1, 8'd9, 1);
        settle_chk("dup9", 5'd2, 8'd9, 1'b0, 1'b0, 1'b0);

        // MUL: enabled computes, disabled flags illegal ahead of underflow.
        send(1'b0, 8'd6, 1'b0, 1'b0, 8'h00, 0);
        send(1'b0, 8'd7, 1'b0, 1'b0, 8'h00, 0);
`ifdef RPN_MUL_EN
        send(1'b1, 8'h02, 1'b0, 1'b1, 8'd42, 4);
        settle_chk("mul", 5'd3, 8'd42, 1'b0, 1'b0, 1'b0);
        reset_dut();
        send(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 0);
        settle_chk("mul_empty", 5'd0, 8'd0, 1'b0, 1'b1, 1'b0);
`else
        send(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 0);
        settle_chk("mul_ill", 5'd4, 8'd7, 1'b0, 1'b0, 1'b1);
        reset_dut();
        send(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 0);
        settle_chk("mul_ill_prio", 5'd0, 8'd0, 1'b0, 1'b0, 1'b1);
`endif

        // Reset during EXEC aborts the operation.
        reset_dut();
        send(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        send(1'b0, 8'd1, 1'b0, 1'b0, 8'h00, 0);
        send(1'b0, 8'd2, 1'b0, 1'b0, 8'h00, 0);
        send(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_rv", {31'h0, result_valid}, 32'd0);
        chk("abort_depth", {27'h0, depth}, 32'd0);
        chk("abort_ready", {31'h0, tok_ready}, 32'd1);
        chk("abort_flags", {29'h0, ovf_err, unf_err, ill_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_late_pulse_depth", {27'h0, depth}, 32'd0);

        // Held tok_valid across a busy operator: operand taken once, after PUSH.
        send(1'b0, 8'd4, 1'b0, 1'b0, 8'h00, 0);
        send(1'b0, 8'd5, 1'b0, 1'b0, 8'h00, 0);
        acc0 = acc_cnt;
        tok_valid = 1'b1; tok_is_op = 1'b1; tok_data = 8'h00;
        @(posedge clk); #1;
        a0 = cyc;
        sb.push_back('{8'd9, 4, a0});
        tok_is_op = 1'b0; tok_data = 8'd77;
        for (int n = 0; n < 20 && !tok_ready; n++) @(negedge clk);
        @(posedge clk); #1;
        tok_valid = 1'b0;
        a1 = cyc;
        chk("held_accept_cycle", a1 - a0, 32'd5);
        chk("held_accept_count", acc_cnt - acc0, 32'd2);
        settle_chk("held", 5'd2, 8'd77, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
